mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-interface stage directly upstream of the 512x32 RAM. Holds MAR (address) and MDR (data), runs a
//  read or write handshake, and returns MDR to the bus. Generates the RAM read/write strobes with a
//  programmable wait-state count. Guarantees read and write are never asserted together, and that MDR
//  captures only while the RAM is actively driving its read data (it is high-Z otherwise).
// PARAMETERS
//  ADDR_W       9   RAM address width (MAR width)
//  DATA_W       32  data width (bus, MDR, RAM word)
//  WAIT_STATES  1   extra ACCESS cycles beyond the first (0..15)
// PORTS
//  clk         in   1       rising-edge clock; the only clock
//  clr         in   1       asynchronous, active-low reset
//  BusMuxOut   in   DATA_W  datapath bus; source for MAR and MDR loads
//  MARin       in   1       load MAR <= BusMuxOut[ADDR_W-1:0] (honoured only in IDLE)
//  MDRin       in   1       load MDR <= BusMuxOut (honoured only in IDLE)
//  rd_req      in   1       start a read of mem[MAR] (sampled only in IDLE)
//  wr_req      in   1       start a write mem[MAR] <= MDR (sampled only in IDLE)
//  Mdatain     in   DATA_W  read data returned by the RAM
//  address     out  ADDR_W  RAM address; always equals MAR
//  read        out  1       RAM read strobe
//  write       out  1       RAM write strobe
//  mem_wdata   out  DATA_W  RAM write data; always equals MDR
//  MDR_q       out  DATA_W  MDR contents, driven back to the bus mux
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle completion pulse
// BEHAVIOUR
//  Reset (clr=0, any time, including mid-access): state=IDLE; MAR=0; MDR=0; read=write=busy=done=0.
//    Every output is 0 while clr is low. An interrupted write leaves RAM contents undefined for that address.
//  FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. The state is held in a 2-bit register.
//  IDLE: MARin and MDRin load at the edge (both may load in the same cycle).
//    wr_req wins over rd_req; if both are high, the cycle performs a write and the read is dropped.
//    A request, together with its direction bit, is latched at the same edge as any MAR/MDR load in that cycle.
//    The access therefore uses the newly loaded values.
//  SETUP (1 cycle): address is stable; read=write=0; busy=1.
//  ACCESS (WAIT_STATES+1 cycles): the wait counter counts down from WAIT_STATES.
//    A read holds read=1; at the edge that leaves ACCESS, MDR <= Mdatain.
//    A write holds write=1 with mem_wdata=MDR.
//  DONE (1 cycle): done=1, busy=1, strobes low; the FSM returns to IDLE at the next edge.
//  Latency: request sampled at edge E0; done is high in the cycle after edge E(WAIT_STATES+2).
//    With the default, that is after the third edge. MDR_q is valid when done=1.
//  While busy: MARin, MDRin, rd_req and wr_req are all ignored; they are not queued.
//  Strobes come from registered state only, so they are glitch-free. read & write == 0 in every cycle.
//  Wait counter width is 4 bits. WAIT_STATES=0 gives a one-cycle ACCESS.
// STRUCTURE
//  Shared include mem_ctrl_defs.vh: state encodings (IDLE=0, SETUP=1, ACCESS=2, DONE=3), ADDR_W/DATA_W defaults.
//  One sub-module, mem_wait_counter: loadable 4-bit down-counter with a zero flag, used in ACCESS.
//  MAR, MDR and the FSM stay in this module.
// TESTING (bench instantiates this block plus the RAM; WAIT_STATES=1)
//  1 Reset: clr=0 mid-ACCESS of a write -> next sample shows all outputs 0, busy=0, MAR=MDR=0.
//  2 Write: MARin with BusMuxOut=0x05, MDRin with 0xDEADBEEF, wr_req -> write=1 for 2 cycles, addr=0x05;
//    done after the third edge; mem[5]=0xDEADBEEF.
//  3 Read-back: MARin 0x05, rd_req -> read=1 for 2 cycles; done pulse; MDR_q=0xDEADBEEF; never read&write.
//  4 Simultaneous rd_req+wr_req in IDLE -> write only; read stays 0 for the whole transaction.
//  5 Requests/MARin pulsed while busy=1 (MAR target 0x1FF) -> ignored; address stays 0x05, a single done pulse.
//  6 Wrap: MAR loaded from BusMuxOut=0x0000_0200 -> address=0x000; read returns mem[0].

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding and width defaults.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mac_state_t;

  localparam int unsigned MAC_ADDR_W = 9;
  localparam int unsigned MAC_DATA_W = 32;
  localparam int unsigned MAC_WCNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter with zero flag; paces the ACCESS phase wait states.
module mem_wait_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  en,
  input  logic [MAC_WCNT_W-1:0] load_val,
  output logic                  zero
);

  logic [MAC_WCNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-interface stage: MAR/MDR registers plus a read/write handshake FSM with
// programmable wait states. Strobes are registered, so read and write never overlap.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = MAC_ADDR_W,
  parameter int unsigned DATA_W      = MAC_DATA_W,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] MDR_q,
  output logic              busy,
  output logic              done
);

  mac_state_t        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              is_wr;
  logic              wait_zero;

  mem_wait_counter u_wait (
    .clk      (clk),
    .clr      (clr),
    .load     (state == ST_SETUP),
    .en       (state == ST_ACCESS),
    .load_val (MAC_WCNT_W'(WAIT_STATES)),
    .zero     (wait_zero)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
      mar   <= '0;
      mdr   <= '0;
      is_wr <= 1'b0;
      read  <= 1'b0;
      write <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr <= BusMuxOut;
          // write wins when both requests arrive together
          if (rd_req || wr_req) begin
            is_wr <= wr_req;
            busy  <= 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          read  <= ~is_wr;
          write <= is_wr;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (wait_zero) begin
            // capture only while the RAM is driving read data
            if (read) mdr <= Mdatain;
            read  <= 1'b0;
            write <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign address   = mar;
  assign mem_wdata = mdr;
  assign MDR_q     = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a behavioural 512x32 RAM and a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, rd_req, wr_req;
  logic [31:0] Mdatain;
  logic [8:0]  address;
  logic        read, write, busy, done;
  logic [31:0] mem_wdata, MDR_q;

  logic [31:0] ram     [512];
  logic [31:0] ref_mem [512];
  logic [8:0]  m_mar;
  logic [31:0] m_mdr;
  int          n_vec = 0;
  int          n_err = 0;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .clr       (clr),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .Mdatain   (Mdatain),
    .address   (address),
    .read      (read),
    .write     (write),
    .mem_wdata (mem_wdata),
    .MDR_q     (MDR_q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write) ram[address] <= mem_wdata;
  assign Mdatain = read ? ram[address] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(address), 32'h0);
    check({tag, "_read"}, 32'(read), 32'h0);
    check({tag, "_write"}, 32'(write), 32'h0);
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mdr"}, MDR_q, 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  task automatic load_reg(input logic [31:0] v, input bit ld_mar, input bit ld_mdr);
    @(negedge clk);
    BusMuxOut = v; MARin = ld_mar; MDRin = ld_mdr;
    if (ld_mar) m_mar = v[8:0];
    if (ld_mdr) m_mdr = v;
    @(negedge clk);
    idle_inputs();
    check("load_addr", 32'(address), 32'(m_mar));
    check("load_mdr", MDR_q, m_mdr);
  endtask

  // noise: 0 none, 1 random inputs while busy, 2 MAR-target 0x1FF pulses while busy
  task automatic run_txn(input bit rd, input bit wr, input bit ld_mar, input bit ld_mdr,
                         input logic [31:0] bus, input int noise);
    int cyc, rd_cyc, wr_cyc, both_cyc;
    bit op_wr, seen;
    rd_cyc = 0; wr_cyc = 0; both_cyc = 0; seen = 1'b0;
    @(negedge clk);
    BusMuxOut = bus; MARin = ld_mar; MDRin = ld_mdr; rd_req = rd; wr_req = wr;
    if (ld_mar) m_mar = bus[8:0];
    if (ld_mdr) m_mdr = bus;
    op_wr = wr;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      idle_inputs();
      if (read && write) both_cyc++;
      if (read) begin
        rd_cyc++;
        check("rd_addr", 32'(address), 32'(m_mar));
      end
      if (write) begin
        wr_cyc++;
        check("wr_addr", 32'(address), 32'(m_mar));
        check("wr_data", mem_wdata, m_mdr);
      end
      check("busy_hi", 32'(busy), 32'h1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noise == 1) begin
        BusMuxOut = $urandom; MARin = 1'($urandom); MDRin = 1'($urandom);
        rd_req = 1'($urandom); wr_req = 1'($urandom);
      end else if (noise == 2) begin
        BusMuxOut = 32'h1FF; MARin = 1'b1; MDRin = 1'($urandom);
        rd_req = 1'b1; wr_req = 1'($urandom);
      end
    end
    check("done_seen", 32'(seen), 32'h1);
    check("latency", 32'(cyc), 32'(WS + 3));
    check("rd_cycles", 32'(rd_cyc), op_wr ? 32'h0 : 32'(WS + 1));
    check("wr_cycles", 32'(wr_cyc), op_wr ? 32'(WS + 1) : 32'h0);
    check("rd_and_wr", 32'(both_cyc), 32'h0);
    if (op_wr) ref_mem[m_mar] = m_mdr;
    else       m_mdr = ref_mem[m_mar];
    check("mdr_at_done", MDR_q, m_mdr);
    check("addr_at_done", 32'(address), 32'(m_mar));
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("single_done", 32'(done), 32'h0);
    check("ram_word", ram[m_mar], ref_mem[m_mar]);
  endtask

  initial begin
    logic [31:0] r;
    bit rd, wr;
    for (int i = 0; i < 512; i++) begin
      r = $urandom;
      ram[i] = r;
      ref_mem[i] = r;
    end
    idle_inputs();
    m_mar = '0; m_mdr = '0;
    clr = 1'b0;
    @(negedge clk); @(negedge clk);
    check_all_zero("por");
    clr = 1'b1;

    // write 0xDEADBEEF to address 5, then read it back
    load_reg(32'h0000_0005, 1'b1, 1'b0);
    load_reg(32'hDEAD_BEEF, 1'b0, 1'b1);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 0);
    check("mem5", ref_mem[5], 32'hDEAD_BEEF);
    load_reg(32'h0000_0005, 1'b1, 1'b0);
    load_reg(32'h0000_0000, 1'b0, 1'b1);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 0);
    check("readback", MDR_q, 32'hDEAD_BEEF);

    // simultaneous requests perform a write only
    load_reg(32'h0000_0077, 1'b1, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5677, 0);

    // requests and MAR loads while busy are ignored
    load_reg(32'h0000_0005, 1'b1, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 2);
    check("noise_addr", 32'(address), 32'h5);

    // MAR takes only the low address bits
    load_reg(32'h0000_0200, 1'b1, 1'b0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, '0, 0);

    // reset in the middle of a write's ACCESS phase
    load_reg(32'h0000_0033, 1'b1, 1'b0);
    load_reg(32'hCAFE_F00D, 1'b0, 1'b1);
    @(negedge clk); wr_req = 1'b1;
    @(negedge clk); idle_inputs();
    @(negedge clk);
    check("pre_rst_write", 32'(write), 32'h1);
    clr = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    clr = 1'b1;
    m_mar = '0; m_mdr = '0;
    ref_mem[9'h033] = ram[9'h033];

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) load_reg($urandom, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) load_reg($urandom, 1'b0, 1'b1);
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      run_txn(rd, wr, 1'($urandom), 1'($urandom), $urandom, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
